i2s_tx_master: RTL and testbench

Parametrised I2S master transmitter, next generation of our SCLK-domain serializer. It runs entirely on SCLK. It generates its own LRCK and serialises stereo samples MSB-first in either Philips I2S or left-justified framing. A one-deep holding buffer with a valid/ready handshake decouples the sample producer from frame timing, and an underrun flag reports frames sent without fresh data.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_frame_counter.sv | 37 +++
 rtl/i2s_tx_master.sv | 131 +++++++++++++
 tb/tb_i2s_tx_master.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: framing-mode constants and frame-length helper.
// No logic; imported by the transmitter and frame counter.
// Exports I2S_MODE_PHILIPS / I2S_MODE_LJ and i2s_frame_len().
package i2s_pkg;

  localparam int I2S_MODE_PHILIPS = 0;  // MSB one SCLK after the LRCK edge
  localparam int I2S_MODE_LJ      = 1;  // MSB coincides with the LRCK edge

  // SCLK periods in one stereo frame (two channel slots).
  function automatic int i2s_frame_len(input int slot_bits);
    return 2 * slot_bits;
  endfunction

endpackage

// File: rtl/i2s_frame_counter.sv
// I2S frame position counter; counts SCLK falling edges over one stereo frame.
// Latency: cnt registered on the falling edge; cnt_next/LRCK_next/frame_wrap are combinational lookahead.
// Ports: SCLK, RST_N in; cnt (current), cnt_next, LRCK_next (LRCK after next edge), frame_wrap (next edge is a frame boundary).
module i2s_frame_counter
  import i2s_pkg::*;
#(
  parameter  int SLOT_BITS = 32,
  localparam int FRAME_LEN = i2s_frame_len(SLOT_BITS),
  localparam int CW        = $clog2(FRAME_LEN)
) (
  input  logic          SCLK,
  input  logic          RST_N,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_next,
  output logic          LRCK_next,
  output logic          frame_wrap
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    frame_wrap = (cnt_q == CW'(FRAME_LEN - 1));
    cnt_d      = frame_wrap ? '0 : cnt_q + CW'(1);
    LRCK_next  = (cnt_d >= CW'(SLOT_BITS));
  end

  // Resetting to the last count makes the first edge after reset a frame boundary.
  always_ff @(negedge SCLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= CW'(FRAME_LEN - 1);
    else        cnt_q <= cnt_d;
  end

  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;

endmodule

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: generates LRCK, serialises stereo samples MSB-first (Philips or left-justified).
// Latency: a pair accepted during frame N is sent in frame N+1; all outputs registered on SCLK falling edge.
// Backpressure: one-deep holding buffer, in_ready = buffer empty; an empty buffer at frame start sends zeros and pulses underrun.
// Ports: SCLK, RST_N, data_in_L/R, in_valid -> in_ready; LRCK, data_out, underrun.
module i2s_tx_master
  import i2s_pkg::*;
#(
  parameter int RESOLUTION = 24,
  parameter int SLOT_BITS  = 32,
  parameter int MODE       = I2S_MODE_PHILIPS
) (
  input  logic                  SCLK,
  input  logic                  RST_N,
  input  logic [RESOLUTION-1:0] data_in_L,
  input  logic [RESOLUTION-1:0] data_in_R,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  LRCK,
  output logic                  data_out,
  output logic                  underrun
);

  localparam int FRAME_LEN = i2s_frame_len(SLOT_BITS);
  localparam int CW        = $clog2(FRAME_LEN);
  localparam int IW        = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;

  logic [CW-1:0] cnt, cnt_next;
  logic          lrck_next, frame_wrap;

  i2s_frame_counter #(.SLOT_BITS(SLOT_BITS)) u_frame_counter (
    .SCLK       (SCLK),
    .RST_N      (RST_N),
    .cnt        (cnt),
    .cnt_next   (cnt_next),
    .LRCK_next  (lrck_next),
    .frame_wrap (frame_wrap)
  );

  logic [RESOLUTION-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [RESOLUTION-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic                  hold_full_q, hold_full_d;
  logic                  lrck_q, data_out_q, data_out_d, underrun_q, underrun_d;
  logic                  accept;
  logic [RESOLUTION-1:0] w_next;
  logic [IW-1:0]         idx;
  logic                  spill_bit;
  int                    p;

  assign accept = in_valid && !hold_full_q;

  // Holding buffer and active-word update. A full buffer never accepts, so an
  // accept can only coincide with an empty-buffer boundary: that frame stays
  // silent and the new pair waits in hold for the following frame.
  always_comb begin
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    underrun_d  = 1'b0;
    if (frame_wrap) begin
      if (hold_full_q) begin
        act_l_d     = hold_l_q;
        act_r_d     = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        act_l_d    = '0;
        act_r_d    = '0;
        underrun_d = 1'b1;
      end
    end
    if (accept) begin
      hold_l_d    = data_in_L;
      hold_r_d    = data_in_R;
      hold_full_d = 1'b1;
    end
  end

  // Serial bit for the slot position the counter moves to on this edge.
  // The spill bit is the LSB of the slot now ending (current cnt, current act),
  // which in Philips mode with a full-width word lands on p=0 of the next slot.
  always_comb begin
    w_next     = lrck_next ? act_r_d : act_l_d;
    spill_bit  = (cnt >= CW'(SLOT_BITS)) ? act_r_q[0] : act_l_q[0];
    p          = int'(cnt_next);
    if (lrck_next) p = p - SLOT_BITS;
    idx        = '0;
    data_out_d = 1'b0;
    if (MODE == I2S_MODE_LJ) begin
      if (p < RESOLUTION) begin
        idx        = IW'(RESOLUTION - 1 - p);
        data_out_d = w_next[idx];
      end
    end else begin
      if (p >= 1 && p <= RESOLUTION) begin
        idx        = IW'(RESOLUTION - p);
        data_out_d = w_next[idx];
      end else if (p == 0 && RESOLUTION == SLOT_BITS) begin
        data_out_d = spill_bit;
      end
    end
  end

  always_ff @(negedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      act_l_q     <= '0;
      act_r_q     <= '0;
      lrck_q      <= 1'b1;
      data_out_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      lrck_q      <= lrck_next;
      data_out_q  <= data_out_d;
      underrun_q  <= underrun_d;
    end
  end

  assign in_ready = !hold_full_q;
  assign LRCK     = lrck_q;
  assign data_out = data_out_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed bench for i2s_tx_master: Philips 24/32, left-justified 24/32 and Philips 32/32 instances.
// Outputs are sampled 1 time unit after each SCLK falling edge; inputs driven at the same point.
// Frames 0..6 are captured slot by slot and compared with hand-derived bit patterns.
module tb_i2s_tx_master;
  import i2s_pkg::*;

  logic        SCLK = 1'b0;
  logic        RST_N;
  logic        in_valid0, in_valid2;
  logic [23:0] data_l0, data_r0;
  logic [31:0] data_l2, data_r2;
  logic        in_ready0, in_ready1, in_ready2;
  logic        lrck0, lrck1, lrck2;
  logic        dout0, dout1, dout2;
  logic        ur0, ur1, ur2;

  always #5 SCLK = ~SCLK;

  i2s_tx_master #(.RESOLUTION(24), .SLOT_BITS(32), .MODE(I2S_MODE_PHILIPS)) dut0 (
    .SCLK(SCLK), .RST_N(RST_N), .data_in_L(data_l0), .data_in_R(data_r0), .in_valid(in_valid0),
    .in_ready(in_ready0), .LRCK(lrck0), .data_out(dout0), .underrun(ur0));

  i2s_tx_master #(.RESOLUTION(24), .SLOT_BITS(32), .MODE(I2S_MODE_LJ)) dut1 (
    .SCLK(SCLK), .RST_N(RST_N), .data_in_L(data_l0), .data_in_R(data_r0), .in_valid(in_valid0),
    .in_ready(in_ready1), .LRCK(lrck1), .data_out(dout1), .underrun(ur1));

  i2s_tx_master #(.RESOLUTION(32), .SLOT_BITS(32), .MODE(I2S_MODE_PHILIPS)) dut2 (
    .SCLK(SCLK), .RST_N(RST_N), .data_in_L(data_l2), .data_in_R(data_r2), .in_valid(in_valid2),
    .in_ready(in_ready2), .LRCK(lrck2), .data_out(dout2), .underrun(ur2));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Pending sample pairs; the front entry is presented until accepted.
  logic [23:0] q0_l[$], q0_r[$];
  logic [31:0] q2_l[$], q2_r[$];
  logic [23:0] dump24;
  logic [31:0] dump32;

  // Expected per-frame content, frames 0..6 (zero = underrun frame).
  localparam logic [23:0] PL_L [7] = '{24'h0, 24'hA5A5A5, 24'h0, 24'hFFFFFF, 24'h800000, 24'h0F0F0F, 24'h0};
  localparam logic [23:0] PL_R [7] = '{24'h0, 24'h5A5A5A, 24'h0, 24'h000001, 24'h123456, 24'hC3C3C3, 24'h0};
  localparam logic [31:0] E2_L [7] = '{32'h0, 32'h0, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0] E2_R [7] = '{32'h0, 32'hC0000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic        UR0  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic        UR2  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic        RDY_B[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic        RDY_A[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic drive_inputs();
    if (q0_l.size() != 0) begin
      in_valid0 = 1'b1; data_l0 = q0_l[0]; data_r0 = q0_r[0];
    end else begin
      in_valid0 = 1'b0; data_l0 = 24'hDEAD5A; data_r0 = 24'hBEEF77;
    end
    if (q2_l.size() != 0) begin
      in_valid2 = 1'b1; data_l2 = q2_l[0]; data_r2 = q2_r[0];
    end else begin
      in_valid2 = 1'b0; data_l2 = 32'hFFFFFFFF; data_r2 = 32'hFFFFFFFF;
    end
  endtask

  // One SCLK falling edge; retire any pair the DUT took on that edge.
  task automatic step();
    logic acc0, acc2;
    acc0 = in_valid0 && in_ready0;
    acc2 = in_valid2 && in_ready2;
    @(negedge SCLK);
    #1;
    if (acc0) begin dump24 = q0_l.pop_front(); dump24 = q0_r.pop_front(); end
    if (acc2) begin dump32 = q2_l.pop_front(); dump32 = q2_r.pop_front(); end
    drive_inputs();
  endtask

  // Capture one full frame starting at its boundary edge, then compare.
  task automatic run_frame(input int f);
    logic [31:0] l0, r0, l1, r1, l2, r2;
    logic [63:0] lr0, lr1, lr2;
    logic        ub0, ub1, ub2, rb0, rb1, ra0, ra1;
    int          ur_extra;
    ur_extra = 0;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0; l2 = '0; r2 = '0;
    lr0 = '0; lr1 = '0; lr2 = '0;
    ub0 = 1'b0; ub1 = 1'b0; ub2 = 1'b0; rb0 = 1'b0; rb1 = 1'b0; ra0 = 1'b0; ra1 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step();
      lr0 = {lr0[62:0], lrck0};
      lr1 = {lr1[62:0], lrck1};
      lr2 = {lr2[62:0], lrck2};
      if (k < 32) begin
        l0 = {l0[30:0], dout0}; l1 = {l1[30:0], dout1}; l2 = {l2[30:0], dout2};
      end else begin
        r0 = {r0[30:0], dout0}; r1 = {r1[30:0], dout1}; r2 = {r2[30:0], dout2};
      end
      if (k == 0) begin
        ub0 = ur0; ub1 = ur1; ub2 = ur2; rb0 = in_ready0; rb1 = in_ready1;
      end else begin
        ur_extra += int'(ur0) + int'(ur1) + int'(ur2);
      end
      if (k == 1) begin ra0 = in_ready0; ra1 = in_ready1; end
    end
    check_val($sformatf("f%0d_phil_left", f),  64'(l0), 64'({1'b0, PL_L[f], 7'b0}));
    check_val($sformatf("f%0d_phil_right", f), 64'(r0), 64'({1'b0, PL_R[f], 7'b0}));
    check_val($sformatf("f%0d_lj_left", f),    64'(l1), 64'({PL_L[f], 8'b0}));
    check_val($sformatf("f%0d_lj_right", f),   64'(r1), 64'({PL_R[f], 8'b0}));
    check_val($sformatf("f%0d_w32_left", f),   64'(l2), 64'(E2_L[f]));
    check_val($sformatf("f%0d_w32_right", f),  64'(r2), 64'(E2_R[f]));
    check_val($sformatf("f%0d_lrck0", f), lr0, {32'h0, 32'hFFFFFFFF});
    check_val($sformatf("f%0d_lrck1", f), lr1, {32'h0, 32'hFFFFFFFF});
    check_val($sformatf("f%0d_lrck2", f), lr2, {32'h0, 32'hFFFFFFFF});
    check_val($sformatf("f%0d_underrun0", f), 64'(ub0), 64'(UR0[f]));
    check_val($sformatf("f%0d_underrun1", f), 64'(ub1), 64'(UR0[f]));
    check_val($sformatf("f%0d_underrun2", f), 64'(ub2), 64'(UR2[f]));
    check_val($sformatf("f%0d_underrun_width", f), 64'(ur_extra), 64'd0);
    check_val($sformatf("f%0d_ready_at_wrap0", f), 64'(rb0), 64'(RDY_B[f]));
    check_val($sformatf("f%0d_ready_at_wrap1", f), 64'(rb1), 64'(RDY_B[f]));
    check_val($sformatf("f%0d_ready_after0", f),   64'(ra0), 64'(RDY_A[f]));
    check_val($sformatf("f%0d_ready_after1", f),   64'(ra1), 64'(RDY_A[f]));
  endtask

  initial begin
    RST_N = 1'b0;
    in_valid0 = 1'b0; data_l0 = '0; data_r0 = '0;
    in_valid2 = 1'b0; data_l2 = '0; data_r2 = '0;
    repeat (2) @(posedge SCLK);
    in_valid0 = 1'b1; data_l0 = 24'h111111; data_r0 = 24'h222222;
    #1 RST_N = 1'b1;

    // First edge after release: boundary with empty buffer, pair taken into hold.
    step();
    check_val("rel_underrun", 64'(ur0), 64'd1);
    check_val("rel_lrck", 64'(lrck0), 64'd0);
    check_val("rel_in_ready", 64'(in_ready0), 64'd0);

    // Mid-frame asynchronous reset, no clock edge needed.
    @(posedge SCLK);
    #1 RST_N = 1'b0;
    #1;
    check_val("rst_lrck0", 64'(lrck0), 64'd1);
    check_val("rst_lrck2", 64'(lrck2), 64'd1);
    check_val("rst_dout0", 64'(dout0), 64'd0);
    check_val("rst_dout1", 64'(dout1), 64'd0);
    check_val("rst_in_ready", 64'(in_ready0), 64'd1);
    check_val("rst_underrun", 64'(ur0), 64'd0);

    q0_l.push_back(24'hA5A5A5); q0_r.push_back(24'h5A5A5A);
    q2_l.push_back(32'h00000001); q2_r.push_back(32'h80000001);
    drive_inputs();
    @(posedge SCLK);
    #1 RST_N = 1'b1;

    run_frame(0);
    run_frame(1);
    q0_l.push_back(24'hFFFFFF); q0_r.push_back(24'h000001);
    q0_l.push_back(24'h800000); q0_r.push_back(24'h123456);
    q0_l.push_back(24'h0F0F0F); q0_r.push_back(24'hC3C3C3);
    drive_inputs();
    for (int f = 2; f < 7; f++) run_frame(f);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
